md_ctrl_d: RTL and testbench

MD_CTRL_D -- requirements
Module: md_ctrl_d

---
 rtl/md_ctrl_d.sv | 102 ++++++++++
 tb/tb_md_ctrl_d.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl_d.sv
// Multiply/divide issue and hazard controller for the D stage.
// Tracks the busy MD unit and produces start, done and HI/LO write pulses.
module md_ctrl_d #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OP,
  input  logic [5:0] F,
  input  logic       valid_D,
  input  logic       stall_ext,
  input  logic       flush,
  output logic       Stall_MD,
  output logic       Busy,
  output logic       Start_E,
  output logic [1:0] MDOp_E,
  output logic       Done,
  output logic [1:0] HiLoWr_E
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic [1:0]       mdop_q, mdop_d;
  logic             done_q, done_d;
  logic [1:0]       hilo_q, hilo_d;

  logic is_r, is_md, is_hilo;
  logic is_mthi, is_mtlo;
  logic pass, issue;

  assign is_r    = (OP == 6'b000000);
  assign is_md   = is_r & (F[5:2] == 4'b0110);
  assign is_hilo = is_r & (F[5:2] == 4'b0100);
  assign is_mthi = is_r & (F == 6'b010001);
  assign is_mtlo = is_r & (F == 6'b010011);

  assign Busy     = (state_q == BUSY);
  assign Stall_MD = valid_D & (is_md | is_hilo) & Busy;

  // an instruction leaves D only when nothing holds or kills it
  assign pass  = valid_D & ~stall_ext & ~Stall_MD & ~flush;
  assign issue = pass & is_md;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    mdop_d  = mdop_q;
    hilo_d  = pass ? {is_mthi, is_mtlo} : 2'b00;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == BUSY) begin
      // countdown runs even while stall_ext holds D
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (issue) begin
      state_d = BUSY;
      cnt_d   = F[1] ? DIV_LD : MULT_LD;
      start_d = 1'b1;
      mdop_d  = F[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      mdop_q  <= 2'b00;
      done_q  <= 1'b0;
      hilo_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      mdop_q  <= mdop_d;
      done_q  <= done_d;
      hilo_q  <= hilo_d;
    end
  end

  assign Start_E  = start_q;
  assign MDOp_E   = mdop_q;
  assign Done     = done_q;
  assign HiLoWr_E = hilo_q;

endmodule

// File: tb/tb_md_ctrl_d.sv
// Scoreboard bench for md_ctrl_d: default instance plus a 1/32-cycle instance.
// Stimulus queues expected events; negedge monitors pop and compare.
module tb_md_ctrl_d;

  localparam int K_START = 0;
  localparam int K_HILO  = 1;
  localparam int K_DONE  = 2;
  localparam int K_BUSY  = 3;
  localparam int K_STALL = 4;

  typedef struct {
    int dut;
    int kind;
    int cyc;
    int val;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] a_op = '0, a_f = '0;
  logic       a_valid = 1'b0, a_stall = 1'b0, a_flush = 1'b0;
  logic       a_stall_md, a_busy, a_start, a_done;
  logic [1:0] a_mdop, a_hilo;
  logic [5:0] b_op = '0, b_f = '0;
  logic       b_valid = 1'b0, b_stall = 1'b0, b_flush = 1'b0;
  logic       b_stall_md, b_busy, b_start, b_done;
  logic [1:0] b_mdop, b_hilo;

  md_ctrl_d u_a (
    .clk(clk), .rst(rst), .OP(a_op), .F(a_f),
    .valid_D(a_valid), .stall_ext(a_stall), .flush(a_flush),
    .Stall_MD(a_stall_md), .Busy(a_busy), .Start_E(a_start),
    .MDOp_E(a_mdop), .Done(a_done), .HiLoWr_E(a_hilo)
  );

  md_ctrl_d #(.MULT_CYCLES(1), .DIV_CYCLES(32), .CNT_W(5)) u_b (
    .clk(clk), .rst(rst), .OP(b_op), .F(b_f),
    .valid_D(b_valid), .stall_ext(b_stall), .flush(b_flush),
    .Stall_MD(b_stall_md), .Busy(b_busy), .Start_E(b_start),
    .MDOp_E(b_mdop), .Done(b_done), .HiLoWr_E(b_hilo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(int k);
    case (k)
      K_START: return "start";
      K_HILO:  return "hilowr";
      K_DONE:  return "done";
      K_BUSY:  return "busy_len";
      default: return "stall_len";
    endcase
  endfunction

  function automatic void exp_ev(int d, int k, int c, int v);
    ev_t e;
    e.dut = d; e.kind = k; e.cyc = c; e.val = v;
    sb.push_back(e);
  endfunction

  function automatic void observe(int d, int k, int v);
    int idx;
    idx = -1;
    checks++;
    foreach (sb[i])
      if (idx < 0 && sb[i].dut == d && sb[i].kind == k) idx = i;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected_%s dut%0d: got cyc=%0d val=%0d, required none",
               kname(k), d, cyc, v);
    end else begin
      if (sb[idx].cyc != cyc || sb[idx].val != v) begin
        errors++;
        $display("FAIL %s dut%0d: got cyc=%0d val=%0d, required cyc=%0d val=%0d",
                 kname(k), d, cyc, v, sb[idx].cyc, sb[idx].val);
      end
      sb.delete(idx);
    end
  endfunction

  task automatic chk(string n, int got, int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", n, got, req);
    end
  endtask

  int a_brun = 0, a_srun = 0, b_brun = 0, b_srun = 0;

  always @(negedge clk) begin
    if (a_start) observe(0, K_START, int'(a_mdop));
    if (a_hilo != 2'b00) observe(0, K_HILO, int'(a_hilo));
    if (a_done) observe(0, K_DONE, 0);
    if (a_busy) a_brun++;
    else if (a_brun > 0) begin observe(0, K_BUSY, a_brun); a_brun = 0; end
    if (a_stall_md) a_srun++;
    else if (a_srun > 0) begin observe(0, K_STALL, a_srun); a_srun = 0; end
  end

  always @(negedge clk) begin
    if (b_start) observe(1, K_START, int'(b_mdop));
    if (b_hilo != 2'b00) observe(1, K_HILO, int'(b_hilo));
    if (b_done) observe(1, K_DONE, 0);
    if (b_busy) b_brun++;
    else if (b_brun > 0) begin observe(1, K_BUSY, b_brun); b_brun = 0; end
    if (b_stall_md) b_srun++;
    else if (b_srun > 0) begin observe(1, K_STALL, b_srun); b_srun = 0; end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(logic v, logic [5:0] f, logic st, logic fl);
    a_valid = v; a_op = 6'b000000; a_f = f; a_stall = st; a_flush = fl;
  endtask

  task automatic chk_a_zero(string n);
    chk({n, "_busy"}, int'(a_busy), 0);
    chk({n, "_start"}, int'(a_start), 0);
    chk({n, "_done"}, int'(a_done), 0);
    chk({n, "_mdop"}, int'(a_mdop), 0);
    chk({n, "_hilo"}, int'(a_hilo), 0);
    chk({n, "_stall"}, int'(a_stall_md), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    #3;
    chk_a_zero("rst_a");
    chk("rst_b_busy", int'(b_busy), 0);
    chk("rst_b_start", int'(b_start), 0);
    step(); step();
    rst = 1'b1;
    step();

    // MULT with defaults
    c = cyc;
    drv_a(1, 6'b011000, 0, 0);
    exp_ev(0, K_START, c + 1, 0);
    exp_ev(0, K_BUSY, c + 6, 5);
    exp_ev(0, K_DONE, c + 6, 0);
    step();
    drv_a(0, 6'b010000, 0, 0);
    repeat (7) step();

    // MULTU
    c = cyc;
    drv_a(1, 6'b011001, 0, 0);
    exp_ev(0, K_START, c + 1, 1);
    exp_ev(0, K_BUSY, c + 6, 5);
    exp_ev(0, K_DONE, c + 6, 0);
    step();
    drv_a(0, 6'b000000, 0, 0);
    repeat (7) step();

    // DIVU then MFLO held in D until the result is valid
    c = cyc;
    drv_a(1, 6'b011011, 0, 0);
    exp_ev(0, K_START, c + 1, 3);
    exp_ev(0, K_BUSY, c + 11, 10);
    exp_ev(0, K_DONE, c + 11, 0);
    exp_ev(0, K_STALL, c + 11, 10);
    step();
    drv_a(1, 6'b010010, 0, 0);
    repeat (10) step();
    step();
    drv_a(0, 6'b000000, 0, 0);
    step();

    // flush in third busy cycle of DIV, then MULT
    c = cyc;
    drv_a(1, 6'b011010, 0, 0);
    exp_ev(0, K_START, c + 1, 2);
    exp_ev(0, K_BUSY, c + 4, 3);
    step();
    drv_a(0, 6'b000000, 0, 0);
    step();
    step();
    drv_a(0, 6'b000000, 0, 1);
    step();
    c = cyc;
    drv_a(1, 6'b011000, 0, 0);
    exp_ev(0, K_START, c + 1, 0);
    exp_ev(0, K_BUSY, c + 6, 5);
    exp_ev(0, K_DONE, c + 6, 0);
    step();
    drv_a(0, 6'b000000, 0, 0);
    repeat (9) step();

    // flush beats a simultaneous issue
    drv_a(1, 6'b011000, 0, 1);
    step();
    drv_a(0, 6'b000000, 0, 0);
    step();

    // stall_ext delays issue; countdown continues under stall_ext
    c = cyc;
    drv_a(1, 6'b011010, 1, 0);
    exp_ev(0, K_START, c + 3, 2);
    exp_ev(0, K_BUSY, c + 13, 10);
    exp_ev(0, K_DONE, c + 13, 0);
    step();
    step();
    drv_a(1, 6'b011010, 0, 0);
    step();
    drv_a(0, 6'b000000, 1, 0);
    repeat (4) step();
    drv_a(0, 6'b000000, 0, 0);
    repeat (9) step();

    // MTHI held by stall_ext for two cycles
    c = cyc;
    drv_a(1, 6'b010001, 1, 0);
    exp_ev(0, K_HILO, c + 3, 2);
    step();
    step();
    drv_a(1, 6'b010001, 0, 0);
    step();
    drv_a(0, 6'b000000, 0, 0);
    step();

    // MTLO plain
    c = cyc;
    drv_a(1, 6'b010011, 0, 0);
    exp_ev(0, K_HILO, c + 1, 1);
    step();
    drv_a(0, 6'b000000, 0, 0);
    step();

    // async reset mid-MULT discards the operation
    c = cyc;
    drv_a(1, 6'b011000, 0, 0);
    exp_ev(0, K_START, c + 1, 0);
    exp_ev(0, K_BUSY, c + 3, 2);
    step();
    drv_a(0, 6'b000000, 0, 0);
    step();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_a_zero("midrst_a");
    step();
    rst = 1'b1;
    repeat (8) step();

    // short/long parameter instance
    c = cyc;
    b_valid = 1'b1; b_f = 6'b011000;
    exp_ev(1, K_START, c + 1, 0);
    exp_ev(1, K_BUSY, c + 2, 1);
    exp_ev(1, K_DONE, c + 2, 0);
    step();
    b_valid = 1'b0;
    step(); step();
    c = cyc;
    b_valid = 1'b1; b_f = 6'b011010;
    exp_ev(1, K_START, c + 1, 2);
    exp_ev(1, K_BUSY, c + 33, 32);
    exp_ev(1, K_DONE, c + 33, 0);
    step();
    b_valid = 1'b0;
    repeat (35) step();

    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL missing_%s dut%0d: got nothing, required cyc=%0d val=%0d",
               kname(sb[i].kind), sb[i].dut, sb[i].cyc, sb[i].val);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
